// File: rtl/dct_pkg.sv
// Shared widths, FSM state encoding and datapath types for the DCT product drain.
package dct_pkg;
  localparam int PROD_W  = 36;
  localparam int TERMS   = 4;
  localparam int ROW_LEN = 8;
  localparam int ACC_W   = PROD_W + $clog2(TERMS);

  typedef enum logic [1:0] {IDLE, RD, CAP, GAP} state_e;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  coef_t;
endpackage

// File: rtl/dct_out_holdreg.sv
// Valid/ready holding register for one coefficient; a load sets valid, an accept clears it.
// Data and last stay frozen while valid is high and ready is low.
module dct_out_holdreg #(
  parameter int ACC_W = dct_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic [ACC_W-1:0] data_o,
  output logic             valid_o,
  output logic             last_o
);
  import dct_pkg::*;

  logic [ACC_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  // Load and accept never coincide: the final-term read waits for the slot to empty.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
endmodule

// File: rtl/dct_product_drain.sv
// Pops signed products from the multiplier FIFO and sums each TERMS group into one coefficient.
// One product per 3 cycles; with out_ready low it pops TERMS-1 more products, then stalls.
module dct_product_drain #(
  parameter int PROD_W  = dct_pkg::PROD_W,
  parameter int TERMS   = dct_pkg::TERMS,
  parameter int ROW_LEN = dct_pkg::ROW_LEN,
  parameter int ACC_W   = PROD_W + $clog2(TERMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [PROD_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);
  import dct_pkg::*;

  localparam int TW = $clog2(TERMS);
  localparam int RW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [TW-1:0] LAST_TERM = TW'(TERMS - 1);
  localparam logic [RW-1:0] LAST_COL  = RW'(ROW_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TW-1:0]    term_q, term_d;
  logic [RW-1:0]    row_q, row_d;

  logic             can_issue;
  logic [ACC_W-1:0] sum;
  logic             hold_load;
  logic             hold_last;

  // The closing read of a group is held back until the output slot is free.
  assign can_issue = !fifo_empty && ((term_q != LAST_TERM) || !out_valid);
  assign sum       = acc_q + {{(ACC_W-PROD_W){fifo_dout[PROD_W-1]}}, fifo_dout};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      term_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      term_q  <= term_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = can_issue ? RD : IDLE;
      RD:      state_d = CAP;
      CAP:     state_d = GAP;
      GAP:     state_d = can_issue ? RD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state_q == RD);
    hold_load  = (state_q == CAP) && (term_q == LAST_TERM);
    hold_last  = (row_q == LAST_COL);
  end

  always_comb begin
    acc_d  = acc_q;
    term_d = term_q;
    row_d  = row_q;
    if (state_q == CAP) begin
      if (term_q == LAST_TERM) begin
        acc_d  = '0;
        term_d = '0;
        row_d  = (row_q == LAST_COL) ? '0 : row_q + RW'(1);
      end else begin
        acc_d  = sum;
        term_d = term_q + TW'(1);
      end
    end
  end

  dct_out_holdreg #(.ACC_W(ACC_W)) u_holdreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load),
    .data_i  (sum),
    .last_i  (hold_last),
    .ready_i (out_ready),
    .data_o  (out_data),
    .valid_o (out_valid),
    .last_o  (out_last)
  );
endmodule

// File: tb/tb_dct_product_drain.sv
// Scoreboard bench: a queue-backed FIFO model feeds the drain; expected coefficients are queued at stimulus time.
module tb_dct_product_drain;
  import dct_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [PROD_W-1:0] fifo_dout = '0;
  logic              fifo_rd_en;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b1;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t  sb[$];
  prod_t fq[$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   pops = 0;
  int   row_pos = 0;
  int   valid_cycles = 0;
  int   last_seen = 0;
  logic force_empty = 1'b0;
  logic samp_empty = 1'b1;

  localparam prod_t MINP = {1'b1, {(PROD_W-1){1'b0}}};
  localparam prod_t MAXP = {1'b0, {(PROD_W-1){1'b1}}};

  always #5 clk = ~clk;

  dct_product_drain dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Empty flag as the DUT saw it at the edge that moved it into RD.
  always @(posedge clk) samp_empty = fifo_empty;

  // FIFO model and output monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) begin
        pops++;
        check_val("rd_while_empty", 64'(samp_empty), 64'(0));
        check_val("fifo_nonempty_on_pop", 64'(fq.size() != 0), 64'(1));
        if (fq.size() != 0) fifo_dout = fq.pop_front();
      end
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_output", 64'(out_valid), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("coef_data", 64'(out_data), 64'(e.data));
          check_val("coef_last", 64'(out_last), 64'(e.last));
          if (out_last) last_seen++;
        end
      end else if (out_valid && sb.size() != 0) begin
        check_val("hold_data", 64'(out_data), 64'(sb[0].data));
      end
    end
    fifo_empty = force_empty || (fq.size() == 0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic exp_group(input prod_t a, input prod_t b, input prod_t c, input prod_t d);
    longint s;
    exp_t   e;
    s = longint'(a) + longint'(b) + longint'(c) + longint'(d);
    e.data = s[ACC_W-1:0];
    e.last = (row_pos == ROW_LEN - 1);
    sb.push_back(e);
    row_pos = (row_pos + 1) % ROW_LEN;
  endtask

  task automatic push_group(input prod_t a, input prod_t b, input prod_t c, input prod_t d);
    exp_group(a, b, c, d);
    fq.push_back(a);
    fq.push_back(b);
    fq.push_back(c);
    fq.push_back(d);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || fq.size() != 0 || out_valid) && n < budget) begin
      tick(1);
      n++;
    end
    check_val({tag, "_drained"}, 64'(n < budget), 64'(1));
    tick(2);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    fq.delete();
    force_empty = 1'b0;
    tick(n);
    rst = 1'b0;
    row_pos = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int n;

    // Reset with the FIFO already holding a group.
    push_group(prod_t'(5), prod_t'(-3), prod_t'(100), prod_t'(-1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rst_rd_en", 64'(fifo_rd_en), 64'(0));
      check_val("rst_out_valid", 64'(out_valid), 64'(0));
      check_val("rst_out_last", 64'(out_last), 64'(0));
      check_val("rst_out_data", 64'(out_data), 64'(0));
    end
    rst = 1'b0;
    valid_cycles = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fifo_rd_en && cyc < 10);
    check_val("first_rd_delay", 64'(cyc), 64'(1));

    // Counting the first RD cycle as cycle 1, the coefficient appears in cycle 12.
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_val("first_coef_latency", 64'(cyc), 64'(12));
    wait_drain("single", 60);
    check_val("single_valid_cycles", 64'(valid_cycles), 64'(1));

    push_group(MINP, MINP, MINP, MINP);
    push_group(MAXP, MAXP, MAXP, MAXP);
    wait_drain("extremes", 100);

    // Back-pressure: three groups queued, downstream stalled.
    out_ready = 1'b0;
    base = pops;
    push_group(prod_t'(1000), prod_t'(-2000), prod_t'(3), prod_t'(4));
    push_group(prod_t'(7), prod_t'(7), prod_t'(7), prod_t'(7));
    push_group(prod_t'(-1), prod_t'(-1), prod_t'(-1), prod_t'(-1));
    tick(60);
    check_val("bp_pops", 64'(pops - base), 64'(7));
    check_val("bp_stall_rd_en", 64'(fifo_rd_en), 64'(0));
    check_val("bp_valid_held", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    n = 0;
    while ((pops - base) < 8 && n < 10) begin
      tick(1);
      n++;
    end
    check_val("bp_fourth_pop", 64'(pops - base), 64'(8));
    wait_drain("backpressure", 120);

    // FIFO running dry and forced empty mid-group.
    base = pops;
    exp_group(prod_t'(11), prod_t'(-22), prod_t'(33), prod_t'(-44));
    fq.push_back(prod_t'(11));
    tick(9);
    fq.push_back(prod_t'(-22));
    force_empty = 1'b1;
    fq.push_back(prod_t'(33));
    tick(7);
    force_empty = 1'b0;
    tick(5);
    fq.push_back(prod_t'(-44));
    wait_drain("empty", 100);
    check_val("empty_pops", 64'(pops - base), 64'(4));

    // One full row from a clean reset.
    do_reset(2);
    last_seen = 0;
    for (int k = 1; k <= ROW_LEN; k++)
      push_group(prod_t'(k), prod_t'(-3 * k), prod_t'(k * k), prod_t'(17));
    wait_drain("row", 300);
    check_val("row_last_count", 64'(last_seen), 64'(1));

    // Reset in the CAP of the second term of a group; the partial sum must vanish.
    base = pops;
    fq.push_back(prod_t'(1000000));
    fq.push_back(prod_t'(2000000));
    fq.push_back(prod_t'(3000000));
    fq.push_back(prod_t'(4000000));
    n = 0;
    while ((pops - base) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("midrst_reached_cap", 64'(pops - base), 64'(2));
    @(posedge clk);
    #2;
    rst = 1'b1;
    fq.delete();
    tick(1);
    check_val("midrst_rd_en", 64'(fifo_rd_en), 64'(0));
    check_val("midrst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    row_pos = 0;
    last_seen = 0;
    for (int k = 1; k <= ROW_LEN; k++)
      push_group(prod_t'(-k), prod_t'(5 * k), prod_t'(-7), prod_t'(k * 100));
    wait_drain("row_after_rst", 300);
    check_val("row_after_rst_last_count", 64'(last_seen), 64'(1));
    check_val("sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
